// File: rtl/div_iter_unit.sv
// Iterative integer divider (DIV/DIVU/REM/REMU) for the M-extension execute stage.
// Retires UNROLL quotient bits per cycle using restoring division.
// Divide-by-zero and signed overflow complete in one cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a one-hot op with enable; fast path resolved here
// S_DIVIDE | UNROLL restoring steps per cycle, counter counts down to 1
// S_DONE   | one-cycle ready pulse, result already registered
module div_iter_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic            clear,
    output logic [XLEN-1:0] result,
    output logic            ready,
    output logic            busy
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    if ((XLEN % UNROLL) != 0) begin : g_bad_unroll
        $error("div_iter_unit: XLEN must be a multiple of UNROLL");
    end
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_radix
        $error("div_iter_unit: UNROLL must be 1, 2, 4 or 8");
    end
    if ((XLEN < 8) || ((XLEN % 2) != 0)) begin : g_bad_xlen
        $error("div_iter_unit: XLEN must be even and at least 8");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] dvd_q, dvd_d;      // dividend shifting out, quotient shifting in
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic            neg_q, neg_d;      // negate the selected final value
    logic            is_rem_q, is_rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            ready_q, ready_d;

    logic            op_onehot, is_signed_op, is_rem_op;
    logic            sign1, sign2, div_zero, sovf;
    logic [XLEN-1:0] mag1, mag2;
    logic [XLEN-1:0] step_rem, step_quo, final_val, final_res;

    // Decode the request and form operand magnitudes for the IDLE launch.
    always_comb begin
        op_onehot    = (op == 4'b1000) || (op == 4'b0100) ||
                       (op == 4'b0010) || (op == 4'b0001);
        is_signed_op = op[3] | op[1];
        is_rem_op    = op[1] | op[0];
        sign1        = rdata1[XLEN-1] & is_signed_op;
        sign2        = rdata2[XLEN-1] & is_signed_op;
        mag1         = sign1 ? (~rdata1 + 1'b1) : rdata1;
        mag2         = sign2 ? (~rdata2 + 1'b1) : rdata2;
        div_zero     = (rdata2 == '0);
        sovf         = is_signed_op && (rdata1 == SMIN) && (rdata2 == '1);
    end

    // UNROLL chained restoring steps; XLEN+1 bit trial keeps the borrow visible.
    always_comb begin : p_steps
        logic [XLEN-1:0] r;
        logic [XLEN-1:0] q;
        logic [XLEN:0]   shifted;
        logic [XLEN:0]   diff;
        r       = rem_q;
        q       = dvd_q;
        shifted = '0;
        diff    = '0;
        for (int i = 0; i < UNROLL; i++) begin
            shifted = {r, q[XLEN-1]};
            diff    = shifted - {1'b0, dvs_q};
            q       = {q[XLEN-2:0], ~diff[XLEN]};
            r       = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        end
        step_rem  = r;
        step_quo  = q;
        final_val = is_rem_q ? step_rem : step_quo;
        final_res = neg_q ? (~final_val + 1'b1) : final_val;
    end

    // Next-state and datapath update; clear overrides everything except reset.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        is_rem_d = is_rem_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable && op_onehot) begin
                    if (div_zero) begin
                        result_d = is_rem_op ? rdata1 : '1;
                        state_d  = S_DONE;
                    end else if (sovf) begin
                        result_d = is_rem_op ? '0 : rdata1;
                        state_d  = S_DONE;
                    end else begin
                        dvd_d    = mag1;
                        dvs_d    = mag2;
                        rem_d    = '0;
                        is_rem_d = is_rem_op;
                        neg_d    = is_rem_op ? sign1 : (sign1 ^ sign2);
                        cnt_d    = CW'(N);
                        state_d  = S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                rem_d = step_rem;
                dvd_d = step_quo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = final_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (clear) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
        ready_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            is_rem_q <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            is_rem_q <= is_rem_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    assign busy   = (state_q != S_IDLE);

endmodule
